// File: rtl/uart_rx_if.sv
// uart_rx_if: byte handshake between the UART receiver and its consumer.
// Ports: go (consumer request, drop = acknowledge), data (received byte),
//        dr (data ready), ferr (framing error, valid with dr).
interface uart_rx_if;
  logic       go;
  logic [7:0] data;
  logic       dr;
  logic       ferr;

  // Consumer side: drives go, reads the byte and its status.
  modport master (
    output go,
    input  data,
    input  dr,
    input  ferr
  );

  // Receiver side: reads go, presents the byte and its status.
  modport slave (
    input  go,
    output data,
    output dr,
    output ferr
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, samples mid-bit, delivers bytes over a go/dr handshake.
// Latency: dr rises BIT_TIME/2 + 9*BIT_TIME clocks after start-edge detection (+1 with majority vote).
// Backpressure: frames are only armed while go=1; a byte is held until go drops, frames arriving meanwhile are dropped.
// Ports: clk (falling-edge clock), rst_n (async active-low reset), rx (async line, idle high),
//        bus (uart_rx_if.slave: go in; data, dr, ferr out).
// Build option: define UART_RX_MAJORITY_EN for a 2-of-3 majority decision per bit.
module uart_rx #(
  parameter int CLK_FREQ  = 66_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rx,
  uart_rx_if.slave bus
);

  localparam int BIT_TIME_RAW = CLK_FREQ / BAUD_RATE;
  localparam int BIT_TIME     = (BIT_TIME_RAW < 4) ? 4 : BIT_TIME_RAW;
  localparam int TW           = $clog2(BIT_TIME);

  localparam logic [TW-1:0] FULL_RELOAD = TW'(BIT_TIME - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(BIT_TIME / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    WAIT_GO_LOW
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    sync;
  logic          rxs;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [2:0]    bcnt, bcnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic [7:0]    data_q, data_nx;
  logic          dr_q, dr_nx;
  logic          ferr_q, ferr_nx;
  logic          armed, armed_nx;
  logic          timed;
  logic          sample_now;
  logic          bit_val;

  // Two-flop synchronizer, idles high so reset never looks like a start bit.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rxs   = sync[1];
  assign timed = (state == START_BIT) || (state == DATA_BITS) || (state == STOP_BIT);

`ifdef UART_RX_MAJORITY_EN
  // Capture rxs at counter 1 and 0; the vote is taken one clock after 0
  // using the live rxs as the third sample.
  logic s_pre;
  logic s_mid;
  logic pend;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_pre <= 1'b1;
      s_mid <= 1'b1;
      pend  <= 1'b0;
    end else begin
      if (timed && (tcnt == TW'(1))) s_pre <= rxs;
      if (timed && (tcnt == '0))     s_mid <= rxs;
      pend <= timed && (tcnt == '0);
    end
  end

  assign sample_now = pend;
  assign bit_val    = (s_pre & s_mid) | (s_pre & rxs) | (s_mid & rxs);
`else
  assign sample_now = timed && (tcnt == '0);
  assign bit_val    = rxs;
`endif

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tcnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      data_q <= '0;
      dr_q   <= 1'b0;
      ferr_q <= 1'b0;
      armed  <= 1'b1;
    end else begin
      state  <= state_nx;
      tcnt   <= tcnt_nx;
      bcnt   <= bcnt_nx;
      shreg  <= shreg_nx;
      data_q <= data_nx;
      dr_q   <= dr_nx;
      ferr_q <= ferr_nx;
      armed  <= armed_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    bcnt_nx  = bcnt;
    shreg_nx = shreg;
    data_nx  = data_q;
    dr_nx    = dr_q;
    ferr_nx  = ferr_q;
    // Any high sample re-arms the start detector after a break.
    armed_nx = armed | rxs;

    // The bit timer free-runs through the frame, reloading at zero, so the
    // sample grid is independent of when the decision is taken.
    if (timed) begin
      tcnt_nx = (tcnt == '0) ? FULL_RELOAD : tcnt - TW'(1);
    end

    case (state)
      IDLE: begin
        if (bus.go && !rxs && armed) begin
          tcnt_nx  = HALF_RELOAD;
          state_nx = START_BIT;
        end
      end

      START_BIT: begin
        if (sample_now) begin
          if (!bit_val) begin
            bcnt_nx  = '0;
            state_nx = DATA_BITS;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      DATA_BITS: begin
        if (sample_now) begin
          shreg_nx[bcnt] = bit_val;
          if (bcnt == 3'd7) begin
            state_nx = STOP_BIT;
          end else begin
            bcnt_nx = bcnt + 3'd1;
          end
        end
      end

      STOP_BIT: begin
        if (sample_now) begin
          data_nx  = shreg;
          ferr_nx  = ~bit_val;
          dr_nx    = 1'b1;
          state_nx = WAIT_GO_LOW;
          if (!bit_val) begin
            armed_nx = 1'b0;
          end
        end
      end

      WAIT_GO_LOW: begin
        if (!bus.go) begin
          dr_nx    = 1'b0;
          ferr_nx  = 1'b0;
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.data = data_q;
  assign bus.dr   = dr_q;
  assign bus.ferr = ferr_q;

endmodule
